// File: rtl/bus_slave_pkg.sv
// Shared constants and FSM state encoding for the serial bus slave.
package bus_slave_pkg;

  localparam int unsigned DefN     = 8;
  localparam int unsigned DefAddrW = 12;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StWrite,
    StRead,
    StWaitBus,
    StTx
  } state_e;

endpackage

// File: rtl/bus_slave_mem.sv
// Single-port synchronous RAM with registered write and registered read.
module bus_slave_mem
  import bus_slave_pkg::*;
#(
  parameter int unsigned N      = DefN,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [N-1:0]      wdata_i,
  output logic [N-1:0]      rdata_o
);

  logic [N-1:0] mem_q [2**ADDR_W];
  logic [N-1:0] rdata_q;

  // No reset: contents stay undefined until written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave.sv
// Serial-bus slave: shifts in address/write data, commits to local RAM, and
// serialises read data back out while the bus is granted.
module bus_slave
  import bus_slave_pkg::*;
#(
  parameter int unsigned N      = DefN,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic clk,
  input  logic rst,
  input  logic validIn,
  input  logic wren,
  input  logic Address,
  input  logic DataIn,
  input  logic BusAvailable,
  output logic ready,
  output logic validOut,
  output logic DataOut
);

  localparam int unsigned CntW = $clog2(ADDR_W);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastBit   = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] DataStart = CntW'(ADDR_W - N);
  localparam logic [IdxW-1:0] LastTx    = IdxW'(N - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   tx_idx_q, tx_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      data_q, data_d;
  logic              is_write_q, is_write_d;

  logic              mem_we;
  logic              mem_re;
  logic [N-1:0]      rd_word;

  // The RAM's registered read port doubles as the transmit word holder.
  bus_slave_mem #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_idx_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_idx_q   <= tx_idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_write_q <= is_write_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_idx_d   = tx_idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_write_d = is_write_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    ready      = 1'b0;
    validOut   = 1'b0;
    DataOut    = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (validIn) begin
          is_write_d = wren;
          cnt_d      = '0;
          state_d    = StRx;
        end
      end
      StRx: begin
        // LSB-first right shifts: after the frame bit 0 sits at position 0.
        addr_d = {Address, addr_q[ADDR_W-1:1]};
        if (is_write_q && (cnt_q >= DataStart)) begin
          data_d = {DataIn, data_q[N-1:1]};
        end
        if (cnt_q == LastBit) begin
          state_d = is_write_q ? StWrite : StRead;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        mem_we  = 1'b1;
        state_d = StIdle;
      end
      StRead: begin
        mem_re   = 1'b1;
        tx_idx_d = '0;
        state_d  = StWaitBus;
      end
      StWaitBus: begin
        ready = 1'b1;
        if (BusAvailable) begin
          state_d = StTx;
        end
      end
      StTx: begin
        if (BusAvailable) begin
          validOut = 1'b1;
          DataOut  = rd_word[tx_idx_q];
          if (tx_idx_q == LastTx) begin
            state_d = StIdle;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_bus_slave.sv
// Randomised scoreboard bench for bus_slave against an array memory model.
module tb_bus_slave;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst, validIn, wren, Address, DataIn, BusAvailable;
  logic ready, validOut, DataOut;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] model [int];
  int            written [$];
  logic          exp_q [$];

  bus_slave #(
    .N      (DW),
    .ADDR_W (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .validIn      (validIn),
    .wren         (wren),
    .Address      (Address),
    .DataIn       (DataIn),
    .BusAvailable (BusAvailable),
    .ready        (ready),
    .validOut     (validOut),
    .DataOut      (DataOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid read bit is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (validOut === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(validOut), 32'd0);
        end else begin
          chk("read_bit", 32'(DataOut), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("dataout_idle", 32'(DataOut), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request frame; returns at #1 after edge E0+AW (or after reset if aborted).
  task automatic send_frame(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int abort_at);
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    validIn = 1'b1;
    wren    = wr;
    tick();
    for (int i = 0; i < AW; i++) begin
      validIn = 1'($urandom_range(0, 1));
      wren    = 1'($urandom_range(0, 1));
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        validIn = 1'b0;
        return;
      end
      ta      = a >> i;
      Address = ta[0];
      if (wr && i >= AW - DW) begin
        td     = d >> (i - (AW - DW));
        DataIn = td[0];
      end else begin
        DataIn = 1'($urandom_range(0, 1));
      end
      chk("ready_in_frame", 32'(ready), 32'd0);
      tick();
    end
    validIn = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send_frame(1'b1, a, d, -1);
    chk("ready_commit", 32'(ready), 32'd0);
    tick();
    chk("ready_after_write", 32'(ready), 32'd1);
    if (!model.exists(int'(a))) written.push_back(int'(a));
    model[int'(a)] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int pre_wait, input int pause_at,
                         input int pause_len, input bit rnd);
    logic [DW-1:0] d;
    int sent;
    int pc;
    int guard;
    d = model[int'(a)];
    for (int i = 0; i < DW; i++) begin
      logic [DW-1:0] t;
      t = d >> i;
      exp_q.push_back(t[0]);
    end
    BusAvailable = (pre_wait == 0);
    send_frame(1'b0, a, 8'($urandom), -1);
    chk("ready_fetch", 32'(ready), 32'd0);
    tick();
    chk("ready_wait_bus", 32'(ready), 32'd1);
    for (int k = 0; k < pre_wait; k++) begin
      BusAvailable = 1'b0;
      validIn      = 1'($urandom_range(0, 1));
      #1;
      chk("valid_withheld", 32'(validOut), 32'd0);
      tick();
      chk("ready_withheld", 32'(ready), 32'd1);
    end
    validIn = 1'b0;
    sent  = 0;
    pc    = 0;
    guard = 0;
    // DW+1 grants: one to leave WAIT_BUS, then one per transmitted bit.
    while (sent < DW + 1 && guard < 300) begin
      if (pause_at >= 0 && sent == pause_at + 2 && pc < pause_len) begin
        BusAvailable = 1'b0;
        pc++;
      end else if (rnd) begin
        BusAvailable = ($urandom_range(0, 3) != 0);
      end else begin
        BusAvailable = 1'b1;
      end
      tick();
      if (BusAvailable) sent++;
      guard++;
    end
    chk("tx_within_budget", 32'(guard < 300), 32'd1);
    chk("ready_after_tx", 32'(ready), 32'd1);
    chk("tx_bits_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; validIn = 1'b0; wren = 1'b0; Address = 1'b0; DataIn = 1'b0;
    BusAvailable = 1'b0;
    tick();
    tick();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_validOut", 32'(validOut), 32'd0);
    chk("reset_DataOut", 32'(DataOut), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    do_write(12'h964, 8'hA7);
    do_read(12'h964, 0, -1, 0, 1'b0);
    do_read(12'h964, 3, -1, 0, 1'b0);
    do_read(12'h964, 0, 3, 2, 1'b0);

    // Aborted overwrite must leave the previous contents intact.
    send_frame(1'b1, 12'h964, 8'h3C, 6);
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_validOut", 32'(validOut), 32'd0);
    chk("abort_DataOut", 32'(DataOut), 32'd0);
    do_read(12'h964, 0, -1, 0, 1'b0);

    do_write(12'h000, 8'h00);
    do_write(12'hFFF, 8'hFF);
    do_read(12'hFFF, 0, -1, 0, 1'b1);
    do_read(12'h000, 1, -1, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        logic [AW-1:0] a;
        a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        do_write(a, DW'($urandom));
      end else begin
        int idx;
        idx = $urandom_range(0, written.size() - 1);
        do_read(AW'(written[idx]), $urandom_range(0, 2), -1, 0, 1'b1);
      end
    end

    tick();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_slave.md
# bus_slave

Serial-bus slave endpoint of the system bus. It receives a 12-bit address and, for writes, 8-bit data serially on 1-bit lines, then stores the data into a local memory. For reads, it fetches the addressed word and shifts it back out serially once the bus is granted. It sits between the bus interconnect (address/data/valid lines plus a BusAvailable grant) and its private storage.

## Interface
- `N`, default 8: data word width (bits per transfer).
- `ADDR_W`, default 12: address width (bits per address frame); memory depth is 2^ADDR_W words.

Ports:
- `clk`, in, 1: the block's only clock; all logic updates on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `validIn`, in, 1: request strobe; a request starts when it is sampled high in IDLE.
- `wren`, in, 1: request type, sampled together with validIn; 1 = write, 0 = read.
- `Address`, in, 1: serial address, LSB first.
- `DataIn`, in, 1: serial write data, LSB first.
- `BusAvailable`, in, 1: bus grant; read data may be driven only while it is high.
- `ready`, out, 1: slave is not mid-frame and not committing/fetching.
- `validOut`, out, 1: DataOut carries a valid read-data bit this cycle.
- `DataOut`, out, 1: serial read data, LSB first.

## Operation
States are IDLE, RX, WRITE, READ, WAIT_BUS and TX.
- **IDLE:** ready=1. On validIn=1:
  - latch wren into an internal `is_write` flag;
  - clear the bit counter;
  - go to RX.
- **RX:** lasts ADDR_W cycles, indexed 0..ADDR_W-1.
  - Cycle i shifts Address into address bit i.
  - On cycles ADDR_W-N+i (i=0..N-1), DataIn is sampled into data bit i. The data field is aligned to the last N address cycles.
  - DataIn is ignored on reads and on cycles 0..ADDR_W-N-1.
  - validIn and wren are ignored during RX.
  - After the last bit: go to WRITE if is_write, else go to READ.
- **WRITE:** one cycle. mem[addr] <= data. Then go to IDLE.
- **READ:** one cycle. Load mem[addr] into the TX shift register, then go to WAIT_BUS.
- **WAIT_BUS:** ready=1. Go to TX when BusAvailable=1. validIn is ignored here.
- **TX:** N bits, LSB first.
  - In each cycle with BusAvailable=1: validOut=1, DataOut=current bit, and the bit index advances.
  - With BusAvailable=0: validOut=0, DataOut=0, and the index holds (pause; no bit is lost).
  - After bit N-1 is driven: go to IDLE.
- **Outputs outside TX:** validOut=0 and DataOut=0.
- **ready:** 1 in IDLE and WAIT_BUS; 0 in RX, WRITE, READ and TX.
- **Memory:** not cleared by reset; contents are undefined until written.

## Timing
- **Reset:** on a rising edge with rst=1, the next state is IDLE, with ready=1, validOut=0, DataOut=0, and counters and shift registers cleared.
  - Reset mid-frame aborts the request; there is no memory write.
  - Reset has priority over all other inputs.
- **Request start:** validIn is sampled high at edge E0. Address bit 0 is sampled at E0+1, and bit ADDR_W-1 at E0+ADDR_W.
- **Write:** memory is updated at edge E0+ADDR_W+1. ready returns to 1 after that edge.
- **Read:** the fetch occurs at edge E0+ADDR_W+1.
  - If BusAvailable is already high, the first DataOut bit is valid in the cycle after entering WAIT_BUS.
  - Transmission then takes N cycles with BusAvailable high (more if it pauses).
- **Back-to-back:** validIn held high when returning to IDLE starts a new request on the next edge.

## Structure
- **Shared package:** default parameter constants (N=8, ADDR_W=12) and the state enum (IDLE, RX, WRITE, READ, WAIT_BUS, TX).
- **Sub-module `bus_slave_mem`:** single-port synchronous RAM, 2^ADDR_W × N, with registered write and read. Instantiated once.
- **Control:** the FSM, serial shifters and counters live in the top module.

## Test plan
- **Reset:** assert rst for 2 cycles → ready=1, validOut=0, DataOut=0.
- **Write:**
  - validIn=1, wren=1, then Address bits 0,0,1,0,0,1,1,0,1,0,0,1 (addr 0x964), with DataIn bits 1,1,1,0,0,1,0,1 on cycles 4..11 (0xA7).
  - Expected: ready=0 during the frame, then rises; mem[0x964]=0xA7.
- **Read with bus granted:** read of 0x964 with BusAvailable=1 → validOut high for 8 cycles, DataOut = 1,1,1,0,0,1,0,1; ready returns high.
- **Read with bus withheld:**
  - Same read, with BusAvailable dropped during the address frame.
  - Expected: ready rises after the fetch and validOut stays 0.
  - Raise BusAvailable 3 cycles later → 0xA7 is shifted out.
- **Mid-transfer pause:** drop BusAvailable for 2 cycles after bit 3 → validOut=0 for 2 cycles; bits 4..7 then follow intact.
- **Reset mid-write frame:** assert rst at address bit 6 → no memory change; a subsequent read returns the prior contents.
